// File: rtl/mem_wb_stage_reg.sv
// MEM->WB pipeline register: 2-entry skid buffer with registered ready, flush and stall counter.
// Optional MEM_WB_JAL_EN adds a Jal path that writes PCAddResult to the link register.
module mem_wb_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] MemReadData,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [REG_AW-1:0] RegRd,
    input  logic              RegWrite,
    input  logic              MemToReg,
`ifdef MEM_WB_JAL_EN
    input  logic [DATA_W-1:0] PCAddResult,
    input  logic              Jal,
    output logic              JalOut,
`endif
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] WriteDataOut,
    output logic [REG_AW-1:0] RegRdOut,
    output logic              RegWriteOut,
    output logic [CNT_W-1:0]  StallCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              main_valid, skid_valid, in_ready;
    logic [DATA_W-1:0] main_data, skid_data, in_data;
    logic [REG_AW-1:0] main_rd, skid_rd, in_rd;
    logic              main_wr, skid_wr;
    logic              main_valid_n, skid_valid_n;
    logic              load_main_in, load_main_skid, load_skid;
    logic              accept, pop;
    logic [CNT_W-1:0]  stall_count;
`ifdef MEM_WB_JAL_EN
    logic              main_jal, skid_jal;
`endif

    assign accept = InValid & in_ready;
    assign pop    = main_valid & OutReady;

    // Writeback data is resolved here so WB only sees one data field per entry.
    always_comb begin
        in_data = MemToReg ? MemReadData : ALUResult;
        in_rd   = RegRd;
`ifdef MEM_WB_JAL_EN
        if (Jal) begin
            in_data = PCAddResult;
            in_rd   = {REG_AW{1'b1}};
        end
`endif
    end

    always_comb begin
        main_valid_n   = main_valid;
        skid_valid_n   = skid_valid;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (Flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (!main_valid || pop) begin
            // Skid holds the older entry, so it refills main before any new input.
            if (skid_valid) begin
                load_main_skid = 1'b1;
                main_valid_n   = 1'b1;
                skid_valid_n   = 1'b0;
            end else if (accept) begin
                load_main_in = 1'b1;
                main_valid_n = 1'b1;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_valid_n = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            main_data  <= '0;
            main_rd    <= '0;
            main_wr    <= 1'b0;
            skid_data  <= '0;
            skid_rd    <= '0;
            skid_wr    <= 1'b0;
`ifdef MEM_WB_JAL_EN
            main_jal   <= 1'b0;
            skid_jal   <= 1'b0;
`endif
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            in_ready   <= !skid_valid_n;
            if (load_main_in) begin
                main_data <= in_data;
                main_rd   <= in_rd;
                main_wr   <= RegWrite;
`ifdef MEM_WB_JAL_EN
                main_jal  <= Jal;
`endif
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_rd   <= skid_rd;
                main_wr   <= skid_wr;
`ifdef MEM_WB_JAL_EN
                main_jal  <= skid_jal;
`endif
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_rd   <= in_rd;
                skid_wr   <= RegWrite;
`ifdef MEM_WB_JAL_EN
                skid_jal  <= Jal;
`endif
            end
        end
    end

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_count <= '0;
        end else if (main_valid && !OutReady && stall_count != CNT_MAX) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

    assign InReady      = in_ready;
    assign OutValid     = main_valid;
    assign WriteDataOut = main_data;
    assign RegRdOut     = main_rd;
    assign StallCount   = stall_count;
`ifdef MEM_WB_JAL_EN
    assign JalOut       = main_valid & main_jal;
    assign RegWriteOut  = main_valid & ((main_wr & (main_rd != '0)) | main_jal);
`else
    assign RegWriteOut  = main_valid & main_wr & (main_rd != '0);
`endif

endmodule
